mem_arbiter: RTL and testbench

Two-port arbiter and sequencer for the single-ported program/data RAM. Sits between the CPU's instruction-fetch port and its load/store port on one side and the RAM's shared tristate data bus on the other. Serializes accesses with round-robin fairness, drives the RAM enables and address, and owns the bidirectional bus during writes. Latches read data per port and rejects out-of-range addresses before they reach the RAM.

---
 rtl/mem_arbiter.sv | 127 ++++++++++++
 tb/tb_mem_arbiter.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Two-port arbiter/sequencer in front of a single-ported RAM with a shared
// tristate data bus. It serializes instruction-fetch (if_*) and load/store
// (dm_*) accesses with round-robin fairness. Each access takes three cycles:
// IDLE (grant), ACCESS (RAM enables active), DONE (ack pulse). Addresses at
// or above MEMDEPTH are rejected with an error and never reach the RAM.
//
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   if_req/if_addr        fetch request, held until if_ack
//   if_rdata/ack/err      registered fetch result, one-cycle ack, range error
//   dm_req/we/addr/wdata  data request, held until dm_ack
//   dm_rdata/ack/err      registered load result, one-cycle ack, range error
//   mem_addr              RAM word address (latched at grant)
//   mem_data              RAM data bus; driven only while a write is in ACCESS
//   mem_rdEn/mem_wrEn     RAM enables, never high together, forced low in reset
module mem_arbiter #(
  parameter int DWIDTH   = 32,
  parameter int AWIDTH   = 10,
  parameter int MEMDEPTH = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [AWIDTH-1:0] if_addr,
  output logic [DWIDTH-1:0] if_rdata,
  output logic              if_ack,
  output logic              if_err,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [AWIDTH-1:0] dm_addr,
  input  logic [DWIDTH-1:0] dm_wdata,
  output logic [DWIDTH-1:0] dm_rdata,
  output logic              dm_ack,
  output logic              dm_err,
  output logic [AWIDTH-1:0] mem_addr,
  inout  wire  [DWIDTH-1:0] mem_data,
  output logic              mem_rdEn,
  output logic              mem_wrEn
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  typedef enum logic {PORT_IF, PORT_DM} port_t;

  // One extra bit so that MEMDEPTH == 2**AWIDTH is representable.
  localparam logic [AWIDTH:0] DEPTH_LIMIT = MEMDEPTH[AWIDTH:0];

  state_t            state;
  port_t             last_grant;
  port_t             cur_port;
  logic              cur_we;
  logic              cur_oor;
  logic [DWIDTH-1:0] cur_wdata;

  logic              grant_dm;
  logic [AWIDTH-1:0] sel_addr;
  logic              sel_oor;
  logic              access_en;

  // DM wins when it is the only requester, or on a tie when IF was served last.
  assign grant_dm = dm_req && (!if_req || last_grant == PORT_IF);
  assign sel_addr = grant_dm ? dm_addr : if_addr;
  assign sel_oor  = {1'b0, sel_addr} >= DEPTH_LIMIT;

  // Gating by reset keeps an aborted access from committing at the reset edge.
  assign access_en = (state == ACCESS) && !cur_oor && !reset;
  assign mem_rdEn  = access_en && !cur_we;
  assign mem_wrEn  = access_en && cur_we;
  assign mem_data  = mem_wrEn ? cur_wdata : {DWIDTH{1'bz}};

  // Sequencer: grant in IDLE, capture read data at the end of ACCESS,
  // hold the ack for exactly the DONE cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= PORT_DM;
      cur_port   <= PORT_IF;
      cur_we     <= 1'b0;
      cur_oor    <= 1'b0;
      cur_wdata  <= '0;
      mem_addr   <= '0;
      if_rdata   <= '0;
      dm_rdata   <= '0;
      if_ack     <= 1'b0;
      dm_ack     <= 1'b0;
      if_err     <= 1'b0;
      dm_err     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (if_req || dm_req) begin
            cur_port   <= grant_dm ? PORT_DM : PORT_IF;
            last_grant <= grant_dm ? PORT_DM : PORT_IF;
            cur_we     <= grant_dm && dm_we;
            cur_wdata  <= dm_wdata;
            cur_oor    <= sel_oor;
            mem_addr   <= sel_addr;
            state      <= ACCESS;
          end
        end
        ACCESS: begin
          state <= DONE;
          if (cur_port == PORT_IF) begin
            if_ack   <= 1'b1;
            if_err   <= cur_oor;
            if_rdata <= cur_oor ? '0 : mem_data;
          end else begin
            dm_ack <= 1'b1;
            dm_err <= cur_oor;
            if (!cur_we) begin
              dm_rdata <= cur_oor ? '0 : mem_data;
            end
          end
        end
        DONE: begin
          state  <= IDLE;
          if_ack <= 1'b0;
          dm_ack <= 1'b0;
          if_err <= 1'b0;
          dm_err <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Self-checking bench for mem_arbiter. A behavioural RAM sits on the shared
// bus. A timing-rule model (grant edge g, enables after g, ack after g+1,
// next grant from g+3) predicts every output; a negedge process compares
// the DUT against it each cycle. Directed scenarios pin literal values, then
// randomized traffic with occasional resets runs against the model.
module tb_mem_arbiter;

  localparam int DW    = 32;
  localparam int AW    = 11;
  localparam int DEPTH = 1024;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic [DW-1:0] if_rdata;
  logic          if_ack;
  logic          if_err;
  logic          dm_req = 1'b0;
  logic          dm_we = 1'b0;
  logic [AW-1:0] dm_addr = '0;
  logic [DW-1:0] dm_wdata = '0;
  logic [DW-1:0] dm_rdata;
  logic          dm_ack;
  logic          dm_err;
  logic [AW-1:0] mem_addr;
  wire  [DW-1:0] mem_data;
  logic          mem_rdEn;
  logic          mem_wrEn;

  int checks = 0;
  int failures = 0;
  bit check_en = 1'b0;
  int rd_cycles = 0;
  int wr_cycles = 0;

  mem_arbiter #(.DWIDTH(DW), .AWIDTH(AW), .MEMDEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .if_ack(if_ack), .if_err(if_err),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ack(dm_ack), .dm_err(dm_err),
    .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_rdEn(mem_rdEn), .mem_wrEn(mem_wrEn)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] init_word(input int i);
    if (i == 5) return 32'hDEADBEEF;
    if (i == 7) return 32'hAAAA0000;
    return 32'(i) * 32'h9E3779B1;
  endfunction

  // RAM on the bus: asynchronous read while rdEn, write at the edge while wrEn.
  logic [DW-1:0] ram [0:DEPTH-1];
  bit ram_init = 1'b0;
  assign mem_data = mem_rdEn ? ram[mem_addr[9:0]] : {DW{1'bz}};

  always @(posedge clk) begin
    if (!ram_init) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= init_word(i);
      ram_init <= 1'b1;
    end else if (mem_wrEn) begin
      ram[mem_addr[9:0]] <= mem_data;
    end
  end

  // Reference model state.
  int            n = 0;
  int            g = 0;
  bit            have = 1'b0;
  bit            last_dm = 1'b1;
  bit            t_dm = 1'b0;
  bit            t_we = 1'b0;
  bit            t_oor = 1'b0;
  int            t_addr = 0;
  logic [DW-1:0] t_wdata = '0;
  logic [DW-1:0] m_if_rdata = '0;
  logic [DW-1:0] m_dm_rdata = '0;
  int            m_addr_out = 0;
  logic [DW-1:0] mram [0:DEPTH-1];
  bit            mram_init = 1'b0;

  // Model: a grant at edge g completes at edge g+1; the port may be granted
  // again no earlier than edge g+3. Reset drops everything in flight.
  always @(posedge clk) begin
    logic [DW-1:0] val;
    if (!mram_init) begin
      for (int i = 0; i < DEPTH; i++) mram[i] = init_word(i);
      mram_init = 1'b1;
    end
    n++;
    if (reset) begin
      have = 1'b0;
      last_dm = 1'b1;
      m_if_rdata = '0;
      m_dm_rdata = '0;
      m_addr_out = 0;
    end else begin
      if (have && n == g + 1) begin
        if (!t_we) begin
          val = t_oor ? '0 : mram[t_addr];
          if (t_dm) m_dm_rdata = val;
          else m_if_rdata = val;
        end else if (!t_oor) begin
          mram[t_addr] = t_wdata;
        end
      end
      if ((!have || n >= g + 3) && (if_req || dm_req)) begin
        t_dm = dm_req && (!if_req || !last_dm);
        last_dm = t_dm;
        t_we = t_dm && dm_we;
        t_addr = t_dm ? int'(dm_addr) : int'(if_addr);
        t_wdata = dm_wdata;
        t_oor = t_addr >= DEPTH;
        m_addr_out = t_addr;
        g = n;
        have = 1'b1;
      end
    end
  end

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Per-cycle comparison against the model, mid-cycle.
  always @(negedge clk) begin
    bit acc;
    bit ackw;
    bit e_rd;
    bit e_wr;
    if (check_en) begin
      acc  = have && (n == g);
      ackw = have && (n == g + 1);
      e_rd = acc && !t_oor && !t_we && !reset;
      e_wr = acc && !t_oor && t_we && !reset;
      check_output("if_ack", 64'(if_ack), 64'(ackw && !t_dm));
      check_output("if_err", 64'(if_err), 64'(ackw && !t_dm && t_oor));
      check_output("dm_ack", 64'(dm_ack), 64'(ackw && t_dm));
      check_output("dm_err", 64'(dm_err), 64'(ackw && t_dm && t_oor));
      check_output("mem_rdEn", 64'(mem_rdEn), 64'(e_rd));
      check_output("mem_wrEn", 64'(mem_wrEn), 64'(e_wr));
      check_output("if_rdata", 64'(if_rdata), 64'(m_if_rdata));
      check_output("dm_rdata", 64'(dm_rdata), 64'(m_dm_rdata));
      check_output("mem_addr", 64'(mem_addr), 64'(m_addr_out));
      if (e_wr) check_output("mem_data", 64'(mem_data), 64'(t_wdata));
      if (mem_rdEn) rd_cycles++;
      if (mem_wrEn) wr_cycles++;
    end
  end

  // Issues one request from an IDLE cycle (called at posedge+2), waits for
  // its ack, returns the latency and result, then waits out the DONE edge.
  task automatic apply_stimulus(input bit dm, input bit we, input int addr,
                                input logic [DW-1:0] wdata, output int lat,
                                output logic [DW-1:0] rdata, output logic err);
    bit acked;
    if (dm) begin
      dm_req = 1'b1; dm_we = we; dm_addr = AW'(addr); dm_wdata = wdata;
    end else begin
      if_req = 1'b1; if_addr = AW'(addr);
    end
    lat = 0;
    acked = 1'b0;
    while (!acked && lat < 20) begin
      @(posedge clk); #2;
      lat++;
      acked = dm ? dm_ack : if_ack;
    end
    checks++;
    if (!acked) begin
      failures++;
      $display("[TB] FAIL ack_timeout actual=no_ack required=ack");
    end
    rdata = dm ? dm_rdata : if_rdata;
    err = dm ? dm_err : if_err;
    if (dm) dm_req = 1'b0;
    else if_req = 1'b0;
    @(posedge clk); #2;
  endtask

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(0, 9) == 0) return AW'($urandom_range(1020, 1030));
    return AW'($urandom_range(0, 63));
  endfunction

  initial begin
    int lat;
    int rd0;
    int wr0;
    int cnt;
    int dbl;
    int mism;
    bit prev;
    bit rst_pulse;
    logic [DW-1:0] rd;
    logic err;

    reset = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check_en = 1'b1;
    check_output("rst_if_ack", 64'(if_ack), 64'd0);
    check_output("rst_dm_ack", 64'(dm_ack), 64'd0);
    check_output("rst_if_rdata", 64'(if_rdata), 64'd0);
    check_output("rst_mem_addr", 64'(mem_addr), 64'd0);
    check_output("rst_mem_rdEn", 64'(mem_rdEn), 64'd0);
    reset = 1'b0;
    @(posedge clk); #2;

    // IF read of a preloaded word.
    rd0 = rd_cycles;
    apply_stimulus(1'b0, 1'b0, 5, '0, lat, rd, err);
    check_output("if_lat", 64'(lat), 64'd2);
    check_output("if_rd5", 64'(rd), 64'hDEADBEEF);
    check_output("if_err5", 64'(err), 64'd0);
    check_output("if_rden_cycles", 64'(rd_cycles - rd0), 64'd1);
    check_output("if_ack_pulse", 64'(if_ack), 64'd0);

    // DM write then read back; IF result must not move.
    wr0 = wr_cycles;
    apply_stimulus(1'b1, 1'b1, 12, 32'h12345678, lat, rd, err);
    check_output("dm_wr_err", 64'(err), 64'd0);
    check_output("dm_wr_cycles", 64'(wr_cycles - wr0), 64'd1);
    apply_stimulus(1'b1, 1'b0, 12, '0, lat, rd, err);
    check_output("dm_rd12", 64'(rd), 64'h12345678);
    check_output("if_rdata_kept", 64'(if_rdata), 64'hDEADBEEF);

    // Range boundary.
    rd0 = rd_cycles;
    wr0 = wr_cycles;
    apply_stimulus(1'b1, 1'b0, 1024, '0, lat, rd, err);
    check_output("oor_err", 64'(err), 64'd1);
    check_output("oor_rdata", 64'(rd), 64'd0);
    check_output("oor_no_enable", 64'((rd_cycles - rd0) + (wr_cycles - wr0)), 64'd0);
    apply_stimulus(1'b1, 1'b1, 1023, 32'hCAFEF00D, lat, rd, err);
    check_output("edge_wr_err", 64'(err), 64'd0);
    apply_stimulus(1'b1, 1'b0, 1023, '0, lat, rd, err);
    check_output("edge_rd1023", 64'(rd), 64'hCAFEF00D);

    // Both ports requesting continuously from reset: IF, DM, IF, DM.
    reset = 1'b1;
    @(posedge clk); #2;
    reset = 1'b0;
    if_req = 1'b1; if_addr = 5;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 12;
    for (int i = 1; i <= 11; i++) begin
      @(posedge clk); #2;
      check_output($sformatf("tie_if_ack_%0d", i), 64'(if_ack), 64'(i == 2 || i == 8));
      check_output($sformatf("tie_dm_ack_%0d", i), 64'(dm_ack), 64'(i == 5 || i == 11));
    end
    if_req = 1'b0;
    dm_req = 1'b0;
    @(posedge clk); #2;

    // Reset during the ACCESS cycle of a write aborts it.
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 7; dm_wdata = 32'h5555;
    @(posedge clk); #2;
    check_output("abort_wren", 64'(mem_wrEn), 64'd1);
    reset = 1'b1;
    dm_req = 1'b0; dm_we = 1'b0;
    @(posedge clk); #2;
    check_output("abort_ram7", 64'(ram[7]), 64'hAAAA0000);
    check_output("abort_dm_ack", 64'(dm_ack), 64'd0);
    check_output("abort_mem_addr", 64'(mem_addr), 64'd0);
    check_output("abort_dm_rdata", 64'(dm_rdata), 64'd0);
    reset = 1'b0;
    @(posedge clk); #2;
    check_output("abort_late_ack", 64'(dm_ack), 64'd0);

    // DM holds its request through the ack: back-to-back single-cycle acks.
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 5;
    cnt = 0; dbl = 0; prev = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #2;
      if (dm_ack) cnt++;
      if (dm_ack && prev) dbl++;
      prev = dm_ack;
    end
    check_output("hold_ack_count", 64'(cnt), 64'd3);
    check_output("hold_ack_double", 64'(dbl), 64'd0);
    check_output("hold_rdata", 64'(dm_rdata), 64'hDEADBEEF);
    dm_req = 1'b0;
    @(posedge clk); #2;

    // Randomized traffic with occasional reset pulses.
    rst_pulse = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      @(posedge clk); #2;
      if (rst_pulse) begin
        reset = 1'b0;
        rst_pulse = 1'b0;
      end else if ($urandom_range(0, 199) == 0) begin
        reset = 1'b1;
        rst_pulse = 1'b1;
        if_req = 1'b0;
        dm_req = 1'b0;
      end else begin
        if (if_req) begin
          if (if_ack) begin
            if ($urandom_range(0, 1) == 1) if_addr = rand_addr();
            else if_req = 1'b0;
          end
        end else if ($urandom_range(0, 2) == 0) begin
          if_req = 1'b1;
          if_addr = rand_addr();
        end
        if (dm_req) begin
          if (dm_ack) begin
            if ($urandom_range(0, 1) == 1) begin
              dm_we = 1'($urandom_range(0, 1));
              dm_addr = rand_addr();
              dm_wdata = $urandom;
            end else begin
              dm_req = 1'b0;
            end
          end
        end else if ($urandom_range(0, 2) == 0) begin
          dm_req = 1'b1;
          dm_we = 1'($urandom_range(0, 1));
          dm_addr = rand_addr();
          dm_wdata = $urandom;
        end
      end
    end
    reset = 1'b0;

    // Let outstanding requests finish.
    for (int c = 0; c < 30 && (if_req || dm_req); c++) begin
      @(posedge clk); #2;
      if (if_req && if_ack) if_req = 1'b0;
      if (dm_req && dm_ack) dm_req = 1'b0;
    end
    checks++;
    if (if_req || dm_req) begin
      failures++;
      $display("[TB] FAIL drain actual=pending required=idle");
      if_req = 1'b0;
      dm_req = 1'b0;
    end
    repeat (4) @(posedge clk);
    #2;

    mism = 0;
    for (int i = 0; i < DEPTH; i++) if (ram[i] !== mram[i]) mism++;
    check_output("ram_contents", 64'(mism), 64'd0);

    check_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
